rr_stream_arbiter: RTL and testbench

- Round-robin arbiter and multiplexer that shares one valid/ready stream datapath of DATA_WIDTH bits between NUM_REQ requesters.
- Single-entry registered output stage: one beat per cycle of throughput, one cycle of accept-to-output latency.
- Sits in front of any shared single-port consumer (FIFO, memory write port, bus master) in common infrastructure.

---
 rtl/rr_stream_arbiter.sv | 123 ++++++++++++
 tb/tb_rr_stream_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// ============================================================================
// Module      : rr_stream_arbiter
// Description : Round-robin arbiter/multiplexer sharing one valid/ready stream
//               between NUM_REQ requesters through a registered output stage.
//               Define RR_STREAM_ARBITER_PACKET_LOCK_EN to hold the grant on a
//               requester until it sends its last beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_stream_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic                          out_last_o,
    output logic [IDX_W-1:0]              out_idx_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_REQ);

    logic                  load_en;
    logic                  accept;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      grant;
    logic                  grant_valid;
    logic [IDX_W-1:0]      next_ptr;
    logic [IDX_W:0]        cand_sum;
    logic [IDX_W-1:0]      cand;
    logic [DATA_WIDTH-1:0] sel_data;

`ifdef RR_STREAM_ARBITER_PACKET_LOCK_EN
    logic                  lock;
    logic [IDX_W-1:0]      locked_idx;
`endif

    assign load_en = ~out_valid_o | out_ready_i;

    // Descending scan so the lowest offset from the pointer is written last and wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand_sum >= NUM_EXT) begin
                cand_sum = cand_sum - NUM_EXT;
            end
            cand = cand_sum[IDX_W-1:0];
            if (req_valid_i[cand]) begin
                grant       = cand;
                grant_valid = 1'b1;
            end
        end
`ifdef RR_STREAM_ARBITER_PACKET_LOCK_EN
        if (lock) begin
            grant       = locked_idx;
            grant_valid = req_valid_i[locked_idx];
        end
`endif
    end

    // No handshakes are offered while reset is held, so nothing is consumed then.
    assign accept = rst_ni & load_en & grant_valid;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    assign next_ptr = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
    assign sel_data = req_data_i[grant*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_idx_o   <= '0;
            ptr         <= '0;
`ifdef RR_STREAM_ARBITER_PACKET_LOCK_EN
            lock        <= 1'b0;
            locked_idx  <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid_o <= 1'b1;
                out_data_o  <= sel_data;
                out_last_o  <= req_last_i[grant];
                out_idx_o   <= grant;
`ifdef RR_STREAM_ARBITER_PACKET_LOCK_EN
                if (req_last_i[grant]) begin
                    lock <= 1'b0;
                    ptr  <= next_ptr;
                end else begin
                    lock       <= 1'b1;
                    locked_idx <= grant;
                end
`else
                ptr <= next_ptr;
`endif
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_stream_arbiter.sv
// Testbench for rr_stream_arbiter: directed scenarios plus random traffic,
// checked against a queue-based reference model through a scoreboard.
`default_nettype none

module tb_rr_stream_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] rdata;
    logic [N-1:0]   rlast;
    logic [N-1:0]   rvalid;
    logic [N-1:0]   rready;
    logic [W-1:0]   odata;
    logic           olast;
    logic [1:0]     oidx;
    logic           ovalid;
    logic           ordy;

    always #5 clk = ~clk;

    rr_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_data_i  (rdata),
        .req_last_i  (rlast),
        .req_valid_i (rvalid),
        .req_ready_o (rready),
        .out_data_o  (odata),
        .out_last_o  (olast),
        .out_idx_o   (oidx),
        .out_valid_o (ovalid),
        .out_ready_i (ordy)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state
    int    m_ptr   = 0;
    bit    m_valid = 1'b0;
    bit    m_lock  = 1'b0;
    int    m_lidx  = 0;
    bit    known   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input int p, input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, predict grant, queue the accepted beat.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                         input logic [N-1:0] l, input logic r, input logic rs,
                         output int g_o);
        int           g;
        logic [N-1:0] er;
        bit           load;
        @(negedge clk);
        #1;
        rvalid = v; rdata = d; rlast = l; ordy = r; rst_n = rs;
        #1;
        g_o = -1;
        if (known) check("out_valid", ovalid, m_valid);
        if (!rs) begin
            q.delete();
            check("ready_in_reset", rready, 0);
            m_ptr = 0; m_valid = 0; m_lock = 0; m_lidx = 0;
            known = 1'b1;
            return;
        end
        load = !m_valid || r;
`ifdef RR_STREAM_ARBITER_PACKET_LOCK_EN
        if (m_lock) g = v[m_lidx] ? m_lidx : -1;
        else        g = first_from(m_ptr, v);
`else
        g = first_from(m_ptr, v);
`endif
        er = (load && g >= 0) ? (N'(1) << g) : '0;
        check("req_ready", rready, er);
        if (load && g >= 0) begin
            g_o = g;
            q.push_back('{idx: g, data: d[g*W +: W], last: l[g]});
            m_valid = 1'b1;
`ifdef RR_STREAM_ARBITER_PACKET_LOCK_EN
            if (!l[g]) begin
                m_lock = 1'b1;
                m_lidx = g;
            end else begin
                m_lock = 1'b0;
                m_ptr  = (g + 1) % N;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (r) begin
            m_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor: a beat leaves whenever valid and ready meet.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n === 1'b1 && ovalid === 1'b1 && ordy === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got idx %0d data %0h expected none", oidx, odata);
                end else begin
                    b = q.pop_front();
                    check("sb_idx", oidx, b.idx);
                    check("sb_data", odata, b.data);
                    check("sb_last", olast, b.last);
                end
            end
        end
    end

    initial begin
        int g;
        int n1;
        int exp_seq[6];
        logic [N*W-1:0] rr_data;
        rr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        rvalid = '0; rdata = '0; rlast = '0; ordy = 1'b0; rst_n = 1'b0;

        // Reset with all requesters pushing
        cycle(4'b1111, rr_data, 4'b1111, 1'b1, 1'b0, g);
        cycle(4'b1111, rr_data, 4'b1111, 1'b1, 1'b0, g);
        check("idx_after_reset", oidx, 0);

        // Round-robin rotation, one beat per cycle
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, rr_data, 4'b1111, 1'b1, 1'b1, g);
            if (i == 0) check("first_grant", g, 0);
            if (i >= 1) begin
                check("rr_idx", oidx, (i - 1) % 4);
                check("rr_data", odata, 8'hA0 + (i - 1) % 4);
            end
        end

        // Move pointer to 3, then sparse valids 0101 must skip 3 and 1
        for (int i = 0; i < 3; i++) cycle(4'b1111, rr_data, 4'b1111, 1'b1, 1'b1, g);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0101, rr_data, 4'b1111, 1'b1, 1'b1, g);
            if (i >= 1) check("skip_idx", oidx, (i % 2 == 1) ? 0 : 2);
        end

        // Backpressure holds the output beat
        cycle(4'b1111, {4{8'h5A}}, 4'b1111, 1'b1, 1'b1, g);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, rr_data, 4'b1111, 1'b0, 1'b1, g);
            check("stall_data", odata, 8'h5A);
        end
        cycle(4'b1111, rr_data, 4'b1111, 1'b1, 1'b1, g);
        check("drain_accept", g >= 0, 1);

        // Packet from requester 1 while 0 and 2 compete
        cycle(4'b0000, rr_data, 4'b0000, 1'b0, 1'b0, g);
        cycle(4'b0001, rr_data, 4'b0001, 1'b1, 1'b1, g);
`ifdef RR_STREAM_ARBITER_PACKET_LOCK_EN
        exp_seq = '{1, 1, 1, 2, 0, 2};
`else
        exp_seq = '{1, 2, 0, 1, 2, 0};
`endif
        n1 = 0;
        for (int k = 0; k < 6; k++) begin
            cycle({1'b0, 1'b1, (n1 < 3), 1'b1}, rr_data, {1'b1, 1'b1, (n1 == 2), 1'b1},
                  1'b1, 1'b1, g);
            if (g == 1) n1++;
            if (k >= 1) check("pkt_idx", oidx, exp_seq[k-1]);
        end

        // Reset in the middle of a stalled packet from requester 2
        cycle(4'b0000, rr_data, 4'b0000, 1'b0, 1'b0, g);
        cycle(4'b0100, rr_data, 4'b0000, 1'b1, 1'b1, g);
        cycle(4'b0100, rr_data, 4'b0000, 1'b0, 1'b1, g);
        cycle(4'b0100, rr_data, 4'b0000, 1'b0, 1'b0, g);
        cycle(4'b1111, rr_data, 4'b1111, 1'b1, 1'b1, g);
        check("post_reset_ready", rready, 4'b0001);
        check("post_reset_valid", ovalid, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(N'($urandom), $urandom, N'($urandom), ($urandom_range(0, 9) < 7), 1'b1, g);
        end

        // Drain
        for (int i = 0; i < 4; i++) cycle(4'b0000, rr_data, 4'b0000, 1'b1, 1'b1, g);
        @(negedge clk);
        #4;
        check("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
